// File: rtl/vga_timing_core.sv
// ---------------------------------------------------------------------------
// vga_timing_core
//
// Parametrised VGA raster timing generator. A clock divider produces one
// pixel advance every CLK_DIV clocks while run is high; the raster position
// (x, y) walks the full H_TOTAL x V_TOTAL grid, and sync/active/strobe
// outputs are decoded from the *next* position so every output register
// changes on the same clock edge as x/y.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset (release is synchronous
//                    to clk at the system level)
//   run         in   1 = timing advances, 0 = everything freezes
//   hs          out  horizontal sync, asserted level = HS_POL
//   vs          out  vertical sync, asserted level = VS_POL
//   x           out  current column, 0..H_TOTAL-1
//   y           out  current row, 0..V_TOTAL-1
//   active      out  1 inside the visible area
//   pix_tick    out  one-clock pulse on each pixel advance
//   line_start  out  1 while x==0
//   frame_start out  1 while x==0 and y==0
//   frame_cnt   out  frames started since reset, wraps modulo 2^FW
// ---------------------------------------------------------------------------
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          hs,
  output logic          vs,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_core: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > (1 << XW)) begin : g_bad_xw
    $error("vga_timing_core: XW too small for H_TOTAL-1");
  end
  if (V_TOTAL > (1 << YW)) begin : g_bad_yw
    $error("vga_timing_core: YW too small for V_TOTAL-1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          active_q, active_d;
  logic          pix_tick_q, pix_tick_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic          in_hs;
  logic          in_vs;

  always_comb begin
    div_d       = div_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    pix_tick_d  = 1'b0;

    if (run) begin
      if (div_q == DIV_LAST) begin
        div_d      = '0;
        pix_tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Advance the raster; the wrap to (0,0) is where a new frame starts,
    // so the frame counter bumps on the same edge frame_start rises.
    if (pix_tick_d) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // Decode from the next position so the registered outputs line up
    // with x/y. While frozen x_d/y_d equal the current position, so the
    // decoded outputs hold naturally.
    in_hs         = (int'(x_d) >= HS_START) && (int'(x_d) < HS_END);
    in_vs         = (int'(y_d) >= VS_START) && (int'(y_d) < VS_END);
    hs_d          = in_hs ? HS_POL : ~HS_POL;
    vs_d          = in_vs ? VS_POL : ~VS_POL;
    active_d      = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
    line_start_d  = (x_d == '0);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      frame_cnt_q   <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      active_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_cnt_q   <= frame_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
